// File: rtl/flash_port_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one flash read port.
// Each granted read either completes with data or is aborted by a BUSY-cycle timeout.
module flash_port_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 24,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int GW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            req_err,
    output logic [DATA_WIDTH-1:0]         req_rdata,
    output logic                          mem_valid,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    input  logic                          mem_ready,
    input  logic [DATA_WIDTH-1:0]         mem_rdata,
    output logic [GW-1:0]                 grant_id,
    output logic                          busy
);

    // Handshake: a requester holds req_valid (and its address) until it sees a
    // one-cycle req_ready; the flash port sees mem_valid held for all of BUSY and
    // completes it with a single-cycle mem_ready strobe carrying mem_rdata.
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [GW-1:0]           last_grant_q;
    logic [GW-1:0]           grant_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    err_q;
    logic [CW-1:0]           cnt_q;
    logic [GW-1:0]           winner;
    logic [GW-1:0]           cand;
    logic                    found;
    logic                    any_req;
    logic                    timeout_hit;

    assign any_req     = |req_valid;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

    // Search upward from the requester after the last grant, wrapping around.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = GW'((int'(last_grant_q) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        mem_valid = 1'b0;
        busy      = 1'b0;
        req_ready = '0;
        req_err   = '0;
        case (state_q)
            S_IDLE: begin
                if (any_req) state_d = S_BUSY;
            end
            S_BUSY: begin
                mem_valid = 1'b1;
                busy      = 1'b1;
                if (mem_ready || timeout_hit) state_d = S_RESP;
            end
            S_RESP: begin
                busy               = 1'b1;
                req_ready[grant_q] = 1'b1;
                req_err[grant_q]   = err_q;
                state_d            = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Data path: latch on grant, capture on completion, clear on return to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= GW'(NUM_REQ - 1);
            grant_q      <= '0;
            addr_q       <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        grant_q      <= winner;
                        last_grant_q <= winner;
                        addr_q       <= req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
                        cnt_q        <= '0;
                        err_q        <= 1'b0;
                    end
                end
                S_BUSY: begin
                    // Data arriving in the expiry cycle takes priority over the abort.
                    if (mem_ready) begin
                        rdata_q <= mem_rdata;
                        err_q   <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    addr_q  <= '0;
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign grant_id  = grant_q;
    assign mem_addr  = addr_q;
    assign req_rdata = rdata_q;

endmodule

// File: tb/tb_flash_port_arbiter.sv
// Randomized bench for flash_port_arbiter against a transaction-level round-robin model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_flash_port_arbiter;

    localparam int N  = 2;
    localparam int AW = 24;
    localparam int DW = 32;
    localparam int TO = 8;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_err;
    logic [DW-1:0]   req_rdata;
    logic            mem_valid;
    logic [AW-1:0]   mem_addr;
    logic            mem_ready;
    logic [DW-1:0]   mem_rdata;
    logic [0:0]      grant_id;
    logic            busy;

    flash_port_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .req_err(req_err), .req_rdata(req_rdata),
        .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .grant_id(grant_id), .busy(busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model state
    logic [DW-1:0] exp_q[$];
    int m_last;
    int m_grant;
    int pulses[N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [N-1:0] pat);
        for (int k = 1; k <= N; k++) begin
            if (pat[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_mem_valid"}, mem_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_req_err"}, req_err, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_req_rdata"}, req_rdata, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_quiet("reset");
        check("reset_grant_id", grant_id, 0);
        @(negedge clk);
        rst = 1'b0;
        m_last  = N - 1;
        m_grant = 0;
        exp_q.delete();
    endtask

    task automatic do_idle(input int n);
        req_valid = '0;
        for (int i = 0; i < n; i++) begin
            mem_ready = 1'(($urandom_range(0, 1)));
            mem_rdata = $urandom;
            @(negedge clk);
            check_quiet("idle");
            check("idle_grant_hold", grant_id, m_grant);
        end
        mem_ready = 1'b0;
    endtask

    // One full transaction, entered and left with the DUT in IDLE at a falling edge.
    // delay d: mem_ready in BUSY cycle d+1; d >= TO means no response (timeout).
    task automatic do_txn(input logic [N-1:0] pat, input int delay, input logic [DW-1:0] data,
                          input logic [AW-1:0] a0, input bit withdraw, input bit noise,
                          output int won);
        logic [AW-1:0] exp_addr;
        logic [N-1:0]  nv;
        bit            timed_out;
        req_valid = pat;
        req_addr[0 +: AW]  = a0;
        req_addr[AW +: AW] = AW'($urandom);
        mem_ready = 1'b0;
        won       = rr_pick(m_last, pat);
        exp_addr  = req_addr[won*AW +: AW];
        timed_out = (delay >= TO);
        @(negedge clk);
        check("t1_mem_valid", mem_valid, 1);
        check("grant_id", grant_id, won);
        check("mem_addr", mem_addr, exp_addr);
        check("busy", busy, 1);
        m_last  = won;
        m_grant = won;
        exp_q.push_back(timed_out ? '0 : data);
        for (int c = 1; c <= TO; c++) begin
            if (c > 1) begin
                check("busy_mem_valid", mem_valid, 1);
                check("busy_mem_addr", mem_addr, exp_addr);
            end
            if (noise) begin
                nv = N'($urandom);
                nv[won] = 1'b1;
                req_valid = nv;
                req_addr  = {AW'($urandom), AW'($urandom)};
            end
            if (withdraw) req_valid[won] = 1'b0;
            mem_ready = (c == delay + 1);
            mem_rdata = (c == delay + 1) ? data : $urandom;
            @(negedge clk);
            mem_ready = 1'b0;
            if (c == delay + 1) break;
        end
        check("resp_req_ready", req_ready, N'(1) << won);
        check("resp_req_err", req_err, timed_out ? (N'(1) << won) : '0);
        check("resp_req_rdata", req_rdata, exp_q.pop_front());
        check("resp_mem_valid", mem_valid, 0);
        check("resp_busy", busy, 1);
        pulses[won] += int'(req_ready[won]);
        mem_ready = noise;
        mem_rdata = $urandom;
        @(negedge clk);
        check_quiet("post_resp");
        check("post_resp_grant", grant_id, m_grant);
        mem_ready = 1'b0;
    endtask

    initial begin
        int won;
        rst = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        do_reset();

        // single request with known address and data
        do_txn(2'b01, 5, 32'hDEADBEEF, 24'h000100, 0, 0, won);
        check("single_won", won, 0);
        do_idle(2);

        // fairness: both held for four transactions
        do_reset();
        pulses[0] = 0;
        pulses[1] = 0;
        for (int i = 0; i < 4; i++) begin
            do_txn(2'b11, $urandom_range(0, 4), $urandom, AW'($urandom), 0, 0, won);
            check("fair_order", won, i % 2);
        end
        check("fair_pulses0", pulses[0], 2);
        check("fair_pulses1", pulses[1], 2);

        // timeout and timeout tie
        do_reset();
        do_txn(2'b01, 20, 32'hCAFEF00D, AW'($urandom), 0, 0, won);
        do_txn(2'b01, TO - 1, 32'h12345678, AW'($urandom), 0, 0, won);

        // reset in the middle of BUSY, requester 1 pending afterwards
        do_reset();
        req_valid = 2'b11;
        req_addr  = {AW'($urandom), AW'($urandom)};
        @(negedge clk);
        check("midrst_grant", grant_id, 0);
        repeat (2) @(negedge clk);
        check("midrst_before", mem_valid, 1);
        #2 rst = 1'b1;
        #1;
        check_quiet("midrst_async");
        req_valid = 2'b10;
        @(negedge clk);
        check("midrst_no_pulse", req_ready, 0);
        rst = 1'b0;
        m_last  = N - 1;
        m_grant = 0;
        do_txn(2'b10, 2, $urandom, AW'($urandom), 0, 0, won);
        check("midrst_regrant", won, 1);

        // withdrawal during BUSY, then nothing pending
        do_txn(2'b01, 3, $urandom, AW'($urandom), 1, 0, won);
        do_idle(3);

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            logic [N-1:0] pat;
            pat = N'($urandom_range(0, 3));
            if (pat == '0) do_idle($urandom_range(1, 2));
            else do_txn(pat, $urandom_range(0, 10), $urandom, AW'($urandom),
                        ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), won);
        end

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flash_port_arbiter.md
FLASH_PORT_ARBITER -- requirements
Module: flash_port_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- NUM_REQ, 2, number of requesters (legal 2..8)
- ADDR_WIDTH, 24, flash byte-address width
- DATA_WIDTH, 32, read-word width
- TIMEOUT_CYCLES, 1024, max BUSY cycles before abort (0 = timeout disabled)
REQ-002 Ports SHALL be, one per line (GW = max(1, $clog2(NUM_REQ))):
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester read request, held until its req_ready
- req_addr  in  NUM_REQ*ADDR_WIDTH  per-requester address; requester i at slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_ready  out  NUM_REQ  one-cycle completion pulse, at most one bit set
- req_err  out  NUM_REQ  one-cycle timeout flag, only coincident with the same req_ready bit
- req_rdata  out  DATA_WIDTH  shared registered read data, valid while any req_ready bit is high
- mem_valid  out  1  request to the flash memory port
- mem_addr  out  ADDR_WIDTH  latched address of the granted requester
- mem_ready  in  1  flash port completion strobe
- mem_rdata  in  DATA_WIDTH  flash read data, valid with mem_ready
- grant_id  out  GW  index of the current or last granted requester
- busy  out  1  high in BUSY and RESP

Function
REQ-003 FSM states SHALL be IDLE, BUSY and RESP only; any illegal encoding SHALL return to IDLE on the next clock.
REQ-004 In IDLE with any req_valid bit high, the FSM SHALL select a winner by round-robin, then register grant_id and that requester's address, then enter BUSY on the next clock.
REQ-005 The round-robin search SHALL start at index (last_grant+1) mod NUM_REQ and proceed upward with wrap-around; last_grant SHALL reset to NUM_REQ-1, which gives requester 0 first priority.
REQ-006 In IDLE with no req_valid bit high, the FSM SHALL stay in IDLE with every output at its reset value, except that grant_id holds its last value.
REQ-007 In BUSY, mem_valid SHALL be 1 and mem_addr SHALL equal the latched address; mem_addr SHALL be stable for the whole of BUSY.
REQ-008 In BUSY, when mem_ready=1, the FSM SHALL register mem_rdata into req_rdata and enter RESP.
REQ-009 In RESP, for exactly one cycle: req_ready[grant_id]=1, mem_valid=0; the FSM SHALL then return to IDLE.
REQ-010 Timing SHALL be as follows:
- req_valid sampled in IDLE at cycle T gives mem_valid=1 at T+1.
- mem_ready at cycle K gives req_ready at K+1.
- The earliest next mem_valid is K+3.
REQ-011 A BUSY cycle counter SHALL clear on entry to BUSY; when it reaches TIMEOUT_CYCLES with no mem_ready, the FSM SHALL enter RESP with req_rdata=0 and req_err[grant_id]=1.
REQ-012 If mem_ready arrives in the same cycle as timeout expiry, data SHALL win: normal completion, req_err=0.
REQ-013 mem_ready in IDLE or RESP SHALL be ignored.
REQ-014 Deassertion of req_valid[grant_id] during BUSY SHALL be ignored; the transaction completes and the completion pulse is still issued.
REQ-015 Changes to req_valid or req_addr of non-granted requesters during BUSY or RESP SHALL have no effect until the next IDLE arbitration.
REQ-016 A requester holding req_valid high after its req_ready SHALL be treated as a new request at the next IDLE arbitration.
REQ-017 last_grant SHALL update to grant_id when the FSM enters BUSY.

Reset
REQ-018 When rst=1, immediately and independently of clk, the block SHALL force:
- state=IDLE, mem_valid=0, mem_addr=0
- req_ready=0, req_err=0, req_rdata=0
- grant_id=0, busy=0, counter=0, last_grant=NUM_REQ-1
REQ-019 A reset asserted mid-BUSY SHALL abort the transaction with no req_ready pulse; after release, pending requests SHALL be re-arbitrated from requester 0.

Verification
REQ-020 Single request: req_valid=01, addr0=0x000100, mem_ready 5 cycles after mem_valid with mem_rdata=0xDEADBEEF -> mem_addr=0x000100; req_ready=01 for one cycle with req_rdata=0xDEADBEEF; req_err=00.
REQ-021 Fairness: both requesters held valid for 4 transactions -> grant order 0,1,0,1; each req_ready bit pulses twice.
REQ-022 Timeout: TIMEOUT_CYCLES=8, mem_ready never asserted -> mem_valid high exactly 8 cycles; req_ready=req_err=01; req_rdata=0.
REQ-023 Timeout tie: mem_ready in the expiry cycle with mem_rdata=0x12345678 -> req_err=00, req_rdata=0x12345678.
REQ-024 Mid-op reset: rst pulsed 3 cycles into BUSY -> mem_valid=0 asynchronously; no req_ready pulse; with requester 1 pending after release, it is granted first on the next mem_valid.
REQ-025 Withdrawal: req_valid[0] dropped during BUSY -> transaction still completes with req_ready=01, and no re-grant of requester 0.
